// File: rtl/life_controller.sv
// Game of Life sequencer: debounces the user buttons, drives the datapath mode
// (clear / edit / run / halt), and issues cell-entry and generation-step pulses.
module life_controller #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CLEAR_CYCLES    = 2,
    parameter int unsigned N_CELLS         = 64,
    parameter int unsigned GEN_PERIOD      = 8
) (
    input  logic        clka,
    input  logic        reset,
    input  logic        btn0_in,
    input  logic        btn1_in,
    input  logic        start_in,
    input  logic        stop_in,
    input  logic [63:0] grid,
    output logic [1:0]  state,
    output logic        btn0,
    output logic        btn1,
    output logic        step,
    output logic        stop,
    output logic [5:0]  cell_idx,
    output logic [15:0] gen_count,
    output logic [1:0]  halt_reason
);

    localparam int unsigned N_IN = 4;
    localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned CL_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
    localparam int unsigned P_W  = $clog2(GEN_PERIOD);

    localparam int unsigned I_BTN0  = 0;
    localparam int unsigned I_BTN1  = 1;
    localparam int unsigned I_START = 2;
    localparam int unsigned I_STOP  = 3;

    typedef enum logic [1:0] {
        S_CLEAR = 2'b00,
        S_EDIT  = 2'b01,
        S_RUN   = 2'b10,
        S_HALT  = 2'b11
    } state_t;

    logic [N_IN-1:0] raw;
    logic [N_IN-1:0] sync1;
    logic [N_IN-1:0] sync2;
    logic [N_IN-1:0] level;
    logic [N_IN-1:0] press;
    logic [DB_W-1:0] db_cnt [N_IN];

    state_t          state_q;
    logic [CL_W-1:0] clr_cnt;
    logic [P_W-1:0]  per_cnt;
    logic            stepped;
    logic [63:0]     snapshot;
    logic            cell_press;
    logic            last_cell;

    assign raw        = {stop_in, start_in, btn1_in, btn0_in};
    assign cell_press = press[I_BTN0] | press[I_BTN1];
    assign last_cell  = (cell_idx == 6'(N_CELLS - 1));
    assign state      = state_q;

    // Synchronise each raw input, then accept a new level after a run of equal samples.
    always_ff @(posedge clka) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            level <= '0;
            press <= '0;
            for (int i = 0; i < N_IN; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int i = 0; i < N_IN; i++) begin
                press[i] <= 1'b0;
                if (sync2[i] == level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    db_cnt[i] <= '0;
                    level[i]  <= sync2[i];
                    press[i]  <= sync2[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    // Mode sequencer with registered pulses; pulses default low every cycle.
    always_ff @(posedge clka) begin
        if (reset) begin
            state_q     <= S_CLEAR;
            btn0        <= 1'b0;
            btn1        <= 1'b0;
            step        <= 1'b0;
            stop        <= 1'b0;
            cell_idx    <= '0;
            gen_count   <= '0;
            halt_reason <= 2'b00;
            clr_cnt     <= '0;
            per_cnt     <= '0;
            stepped     <= 1'b0;
            snapshot    <= '0;
        end else begin
            btn0 <= 1'b0;
            btn1 <= 1'b0;
            step <= 1'b0;
            case (state_q)
                S_CLEAR: begin
                    if (clr_cnt == CL_W'(CLEAR_CYCLES - 1)) begin
                        clr_cnt <= '0;
                        state_q <= S_EDIT;
                    end else begin
                        clr_cnt <= clr_cnt + CL_W'(1);
                    end
                end
                S_EDIT: begin
                    if (cell_press) begin
                        // A live entry wins over a simultaneous dead entry.
                        btn1     <= press[I_BTN1];
                        btn0     <= press[I_BTN0] & ~press[I_BTN1];
                        cell_idx <= last_cell ? 6'd0 : cell_idx + 6'd1;
                    end
                    if (press[I_START] || (cell_press && last_cell)) begin
                        state_q   <= S_RUN;
                        per_cnt   <= '0;
                        stepped   <= 1'b0;
                        gen_count <= '0;
                    end
                end
                S_RUN: begin
                    if (press[I_STOP]) begin
                        state_q     <= S_HALT;
                        halt_reason <= 2'b11;
                        stop        <= 1'b1;
                    end else begin
                        if (per_cnt == P_W'(GEN_PERIOD - 1)) begin
                            per_cnt  <= '0;
                            step     <= 1'b1;
                            stepped  <= 1'b1;
                            snapshot <= grid;
                            if (gen_count != 16'hFFFF) begin
                                gen_count <= gen_count + 16'd1;
                            end
                        end else begin
                            per_cnt <= per_cnt + P_W'(1);
                        end
                        // Judge the grid one cycle before the next step is due.
                        if (stepped && (per_cnt == P_W'(GEN_PERIOD - 2))) begin
                            if (grid == 64'd0) begin
                                state_q     <= S_HALT;
                                halt_reason <= 2'b01;
                                stop        <= 1'b1;
                            end else if (grid == snapshot) begin
                                state_q     <= S_HALT;
                                halt_reason <= 2'b10;
                                stop        <= 1'b1;
                            end
                        end
                    end
                end
                S_HALT: begin
                    stop <= 1'b1;
                    if (press[I_START]) begin
                        state_q     <= S_CLEAR;
                        stop        <= 1'b0;
                        cell_idx    <= '0;
                        gen_count   <= '0;
                        halt_reason <= 2'b00;
                        clr_cnt     <= '0;
                    end
                end
                default: state_q <= S_CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_life_controller.sv
// Directed bench for life_controller: debounce timing, cell entry, run pacing and halt causes.
module tb_life_controller;

    logic        clka = 1'b0;
    logic        reset;
    logic        btn0_in;
    logic        btn1_in;
    logic        start_in;
    logic        stop_in;
    logic [63:0] grid;
    logic [1:0]  state;
    logic        btn0;
    logic        btn1;
    logic        step;
    logic        stop;
    logic [5:0]  cell_idx;
    logic [15:0] gen_count;
    logic [1:0]  halt_reason;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [63:0] PATTERN = 64'h0000_0018_2418_0000;

    life_controller dut (
        .clka(clka), .reset(reset),
        .btn0_in(btn0_in), .btn1_in(btn1_in), .start_in(start_in), .stop_in(stop_in),
        .grid(grid), .state(state), .btn0(btn0), .btn1(btn1), .step(step), .stop(stop),
        .cell_idx(cell_idx), .gen_count(gen_count), .halt_reason(halt_reason)
    );

    always #5 clka = ~clka;

    task automatic tick();
        @(posedge clka);
        #1;
    endtask

    task automatic release_inputs();
        btn0_in  = 1'b0;
        btn1_in  = 1'b0;
        start_in = 1'b0;
        stop_in  = 1'b0;
        for (int i = 0; i < 7; i++) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        btn0_in = 1'b0; btn1_in = 1'b0; start_in = 1'b0; stop_in = 1'b0;
        grid = 64'd0;
        for (int i = 0; i < 3; i++) tick();
        n_checks++; if (state !== 2'b00) begin n_fail++; $display("FAIL reset_state got %0h want 0", state); end
        n_checks++; if ({btn0, btn1, step, stop} !== 4'b0000) begin n_fail++; $display("FAIL reset_pulses got %b want 0000", {btn0, btn1, step, stop}); end
        n_checks++; if (cell_idx !== 6'd0) begin n_fail++; $display("FAIL reset_cell_idx got %0d want 0", cell_idx); end
        n_checks++; if (gen_count !== 16'd0) begin n_fail++; $display("FAIL reset_gen_count got %0d want 0", gen_count); end
        n_checks++; if (halt_reason !== 2'b00) begin n_fail++; $display("FAIL reset_halt_reason got %0h want 0", halt_reason); end
        reset = 1'b0;
        tick();
        n_checks++; if (state !== 2'b00) begin n_fail++; $display("FAIL clear_cycle2 got %0h want 0", state); end
        tick();
        n_checks++; if (state !== 2'b01) begin n_fail++; $display("FAIL enter_edit got %0h want 1", state); end
    endtask

    task automatic test_debounce();
        btn1_in = 1'b1;
        tick(); tick();
        btn1_in = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_checks++; if ({btn0, btn1} !== 2'b00) begin n_fail++; $display("FAIL glitch_pulse cyc=%0d got %b want 00", i, {btn0, btn1}); end
        end
        n_checks++; if (cell_idx !== 6'd0) begin n_fail++; $display("FAIL glitch_cell_idx got %0d want 0", cell_idx); end
        btn1_in = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            n_checks++; if (btn1 !== 1'b0) begin n_fail++; $display("FAIL early_pulse k=%0d got %b want 0", k, btn1); end
        end
        tick();
        n_checks++; if ({btn0, btn1} !== 2'b01) begin n_fail++; $display("FAIL held_pulse got %b want 01", {btn0, btn1}); end
        n_checks++; if (cell_idx !== 6'd1) begin n_fail++; $display("FAIL held_cell_idx got %0d want 1", cell_idx); end
        tick();
        n_checks++; if (btn1 !== 1'b0) begin n_fail++; $display("FAIL pulse_width got %b want 0", btn1); end
        release_inputs();
    endtask

    task automatic test_simultaneous();
        btn0_in = 1'b1;
        btn1_in = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        n_checks++; if ({btn0, btn1} !== 2'b01) begin n_fail++; $display("FAIL live_wins got %b want 01", {btn0, btn1}); end
        n_checks++; if (cell_idx !== 6'd2) begin n_fail++; $display("FAIL both_cell_idx got %0d want 2", cell_idx); end
        tick();
        n_checks++; if ({btn0, btn1} !== 2'b00 || cell_idx !== 6'd2) begin n_fail++; $display("FAIL single_incr got %b/%0d want 00/2", {btn0, btn1}, cell_idx); end
        release_inputs();
    endtask

    task automatic test_fill_to_run();
        logic exp_live;
        int   exp_idx;
        grid = PATTERN;
        for (int i = 0; i < 62; i++) begin
            exp_live = (i % 2 == 1);
            if (exp_live) btn1_in = 1'b1; else btn0_in = 1'b1;
            for (int t = 0; t < 7; t++) tick();
            exp_idx = (3 + i) % 64;
            n_checks++; if ({btn0, btn1} !== {~exp_live, exp_live}) begin n_fail++; $display("FAIL fill_pulse i=%0d got %b want %b", i, {btn0, btn1}, {~exp_live, exp_live}); end
            n_checks++; if (cell_idx !== 6'(exp_idx)) begin n_fail++; $display("FAIL fill_cell_idx i=%0d got %0d want %0d", i, cell_idx, exp_idx); end
            n_checks++; if (state !== ((i == 61) ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL fill_state i=%0d got %0h", i, state); end
            if (i < 61) release_inputs();
        end
        btn0_in = 1'b0;
        btn1_in = 1'b0;
    endtask

    task automatic test_stable_halt();
        for (int k = 1; k <= 15; k++) begin
            tick();
            n_checks++; if (step !== (k == 8)) begin n_fail++; $display("FAIL stable_step k=%0d got %b want %b", k, step, (k == 8)); end
            if (k == 8) begin
                n_checks++; if (gen_count !== 16'd1) begin n_fail++; $display("FAIL stable_gen_count got %0d want 1", gen_count); end
            end
            if (k == 14) begin
                n_checks++; if (state !== 2'b10) begin n_fail++; $display("FAIL stable_still_run got %0h want 2", state); end
            end
        end
        n_checks++; if (state !== 2'b11) begin n_fail++; $display("FAIL stable_halt_state got %0h want 3", state); end
        n_checks++; if (halt_reason !== 2'b10) begin n_fail++; $display("FAIL stable_reason got %0h want 2", halt_reason); end
        n_checks++; if (stop !== 1'b1) begin n_fail++; $display("FAIL stable_stop got %b want 1", stop); end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++; if ({step, stop, state} !== 4'b0111 || gen_count !== 16'd1) begin n_fail++; $display("FAIL halt_hold got %b/%0d want 0111/1", {step, stop, state}, gen_count); end
        end
    endtask

    task automatic test_restart();
        start_in = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        n_checks++; if (state !== 2'b00) begin n_fail++; $display("FAIL restart_state got %0h want 0", state); end
        n_checks++; if (gen_count !== 16'd0 || halt_reason !== 2'b00) begin n_fail++; $display("FAIL restart_counters got %0d/%0h want 0/0", gen_count, halt_reason); end
        n_checks++; if (cell_idx !== 6'd0 || stop !== 1'b0) begin n_fail++; $display("FAIL restart_idx_stop got %0d/%b want 0/0", cell_idx, stop); end
        start_in = 1'b0;
        tick();
        n_checks++; if (state !== 2'b00) begin n_fail++; $display("FAIL restart_clear2 got %0h want 0", state); end
        tick();
        n_checks++; if (state !== 2'b01) begin n_fail++; $display("FAIL restart_edit got %0h want 1", state); end
        for (int i = 0; i < 6; i++) tick();
    endtask

    task automatic test_extinct();
        btn1_in = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        n_checks++; if (cell_idx !== 6'd1) begin n_fail++; $display("FAIL pre_start_idx got %0d want 1", cell_idx); end
        release_inputs();
        grid = PATTERN;
        start_in = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        n_checks++; if (state !== 2'b10 || cell_idx !== 6'd1) begin n_fail++; $display("FAIL start_run got %0h/%0d want 2/1", state, cell_idx); end
        start_in = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            tick();
            n_checks++; if (step !== (k == 8)) begin n_fail++; $display("FAIL extinct_step k=%0d got %b want %b", k, step, (k == 8)); end
            if (k == 8) grid = 64'd0;
            if (k == 14) begin
                n_checks++; if (state !== 2'b10) begin n_fail++; $display("FAIL extinct_still_run got %0h want 2", state); end
            end
        end
        n_checks++; if (state !== 2'b11 || halt_reason !== 2'b01 || stop !== 1'b1) begin n_fail++; $display("FAIL extinct_halt got %0h/%0h/%b want 3/1/1", state, halt_reason, stop); end
        grid = PATTERN;
    endtask

    task automatic test_stop_vs_step();
        start_in = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        n_checks++; if (state !== 2'b10) begin n_fail++; $display("FAIL stop_test_run got %0h want 2", state); end
        start_in = 1'b0;
        tick();
        stop_in = 1'b1;
        for (int k = 2; k <= 8; k++) begin
            tick();
            n_checks++; if (step !== 1'b0) begin n_fail++; $display("FAIL stop_step k=%0d got %b want 0", k, step); end
            if (k < 8) begin
                n_checks++; if (state !== 2'b10) begin n_fail++; $display("FAIL stop_early k=%0d got %0h want 2", k, state); end
            end
        end
        n_checks++; if (state !== 2'b11 || halt_reason !== 2'b11) begin n_fail++; $display("FAIL user_stop got %0h/%0h want 3/3", state, halt_reason); end
        n_checks++; if (stop !== 1'b1 || gen_count !== 16'd0) begin n_fail++; $display("FAIL user_stop_out got %b/%0d want 1/0", stop, gen_count); end
        stop_in = 1'b0;
    endtask

    task automatic test_reset_in_halt();
        tick();
        reset = 1'b1;
        tick();
        n_checks++; if (state !== 2'b00 || stop !== 1'b0) begin n_fail++; $display("FAIL halt_reset got %0h/%b want 0/0", state, stop); end
        n_checks++; if (halt_reason !== 2'b00 || step !== 1'b0) begin n_fail++; $display("FAIL halt_reset_misc got %0h/%b want 0/0", halt_reason, step); end
        reset = 1'b0;
        tick();
        tick();
        n_checks++; if (state !== 2'b01) begin n_fail++; $display("FAIL post_reset_edit got %0h want 1", state); end
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_simultaneous();
        test_fill_to_run();
        test_stable_halt();
        test_restart();
        test_extinct();
        test_restart();
        test_stop_vs_step();
        test_reset_in_halt();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
